rf_scoreboard: RTL and testbench
================================

Name: rf_scoreboard

Overview:
- Tracks register-file destinations of in-flight long-latency ops (mul/div unit) and stalls decode on RAW/WAW hazards against them.
- Shares the single register-file write port between normal pipeline writeback and long-unit results.
- Sits beside the decode stage: drives the stall into the IF/ID/EX hazard logic and owns the regfile write address, data and enable.

Parameters:
- XLEN, 32, datapath width.
- DEPTH, 4, max outstanding long ops; power of 2, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_rs1  in  5  source 1 index
- id_rs2  in  5  source 2 index
- id_rd  in  5  destination index
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_reg_write  in  1  instruction writes rd
- id_long  in  1  instruction goes to the long unit; implies id_reg_write
- stall_d  out  1  hold decode and fetch, bubble EX
- lu_issue  out  1  long op accepted this cycle
- lu_done_valid  in  1  long unit presents a result
- lu_done_data  in  XLEN  long-unit result
- lu_done_ready  out  1  result accepted this cycle
- wb_reg_write  in  1  pipeline writeback enable (W stage)
- wb_rd  in  5  pipeline writeback index
- wb_result  in  XLEN  pipeline writeback data
- rf_we  out  1  regfile write enable
- rf_wa  out  5  regfile write address
- rf_wd  out  XLEN  regfile write data
- pending_cnt  out  clog2(DEPTH)+1  outstanding long ops

Behaviour:
- Reset (reset=0, asynchronous):
  - busy[31:0]=0, tag FIFO empty, pending_cnt=0, hold_valid=0.
  - Outputs: stall_d=0, lu_issue=0, lu_done_ready=1 only if the FIFO is non-empty (so 0 at reset), rf_we=0.
  - Reset mid-operation discards every pending tag and held result.
- Hazard (combinational):
  - stall_d = id_valid & (RAW1 | RAW2 | WAW | FULL), where:
  - RAW1 = id_use_rs1 & rs1≠0 & busy[rs1].
  - RAW2 = id_use_rs2 & rs2≠0 & busy[rs2].
  - WAW = id_reg_write & rd≠0 & busy[rd].
  - FULL = id_long & pending_cnt==DEPTH, using the registered count; a same-cycle drain does not unblock.
- Issue:
  - lu_issue = id_valid & id_long & ~stall_d.
  - On lu_issue: push id_rd to the tag FIFO and pending_cnt+1.
  - Also on lu_issue: set busy[id_rd], unless id_rd==0.
  - rd=0 long ops still take a FIFO slot, with the write suppressed at drain.
- Completion:
  - The long unit completes in issue order; the destination is the FIFO head.
  - lu_done_ready = FIFO non-empty & (~hold_valid | hold_drain).
  - Accept (valid & ready): pop the FIFO and load hold_rd, hold_data; hold_valid=1.
  - lu_done_valid while the FIFO is empty is ignored (ready=0).
- Write-port arbitration (combinational, fixed priority):
  - Pipeline first: if wb_reg_write & wb_rd≠0, then rf_we=1, rf_wa=wb_rd, rf_wd=wb_result.
  - Otherwise, if hold_valid, the hold register drains: rf_we = (hold_rd≠0), rf_wa=hold_rd, rf_wd=hold_data.
  - Otherwise rf_we=0, rf_wa=0, rf_wd=0.
  - hold_drain = hold_valid & ~(wb_reg_write & wb_rd≠0).
- On the drain edge:
  - hold_valid clears, unless refilled that same cycle.
  - busy[hold_rd] clears and pending_cnt-1.
  - Issue and drain in the same cycle leave pending_cnt unchanged.
- Latency and stall release:
  - Minimum latency from result acceptance to regfile write is 1 cycle; the hold register drains in the cycle after acceptance.
  - The dependent instruction's stall drops the cycle after the write edge, because the busy clear and the regfile write share that edge.
- Invariants:
  - A pipeline write to a busy register cannot occur, because WAW stalls at decode.
  - busy[0] is constantly 0.
  - pending_cnt never exceeds DEPTH and never underflows.

Decomposition:
- Shared package rf_sb_pkg:
  - REG_IDX_W=5 and the regidx_t typedef.
  - A struct for the hold entry {valid, rd, data}.
- One sub-module, rd_tag_fifo: DEPTH×5 synchronous FIFO with push/pop/full/empty/head, the same async active-low reset, and wrap-around pointers one bit wider than the index.

Test Plan:
1. RAW on a long op: issue a long op with rd=5; next decode reads rs1=5 → stall_d=1 until the result writes x5; stall_d=0 the following cycle.
2. Port conflict: lu_done_valid (x7, 0xDEADBEEF) accepted while wb_reg_write=1 with wb_rd=3 for 2 cycles → x3 is written first and the hold stays valid, lu_done_ready=0 the next cycle; x7 is written on cycle 3.
3. Full: issue 4 long ops to rd 1..4 with no completion → pending_cnt=4; a 5th long op stalls; one drain → the 5th issues the cycle after, pending_cnt stays 4.
4. In-order tags: complete 3 results (0x11, 0x22, 0x33) for issue order rd=8, 9, 10 → rf_wa sequence 8, 9, 10 with matching data; busy bits clear individually.
5. x0 and WAW: a long op with rd=0 writes nothing and never stalls rs1=0 readers; a non-long write to a busy rd=6 → stall_d=1 until x6 drains.
6. Async reset: with 2 ops pending and the hold valid, assert reset between clock edges → outputs reset immediately; pending_cnt=0, no spurious rf_we after release.

Source files
------------

// File: rtl/rf_sb_pkg.sv
// Shared types for the register-file scoreboard: register index width and
// the register count that the busy vector spans.
package rf_sb_pkg;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 1 << REG_IDX_W;

  typedef logic [REG_IDX_W-1:0] regidx_t;
endpackage

// File: rtl/rf_scoreboard_if.sv
// Decode, long-unit, writeback and regfile-port signals of the scoreboard.
// master drives decode/long-unit/writeback inputs, slave is the scoreboard.
interface rf_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  import rf_sb_pkg::*;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             id_valid;
  regidx_t          id_rs1;
  regidx_t          id_rs2;
  regidx_t          id_rd;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_reg_write;
  logic             id_long;
  logic             stall_d;
  logic             lu_issue;
  logic             lu_done_valid;
  logic [XLEN-1:0]  lu_done_data;
  logic             lu_done_ready;
  logic             wb_reg_write;
  regidx_t          wb_rd;
  logic [XLEN-1:0]  wb_result;
  logic             rf_we;
  regidx_t          rf_wa;
  logic [XLEN-1:0]  rf_wd;
  logic [CNT_W-1:0] pending_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_reg_write, id_long, lu_done_valid, lu_done_data,
           wb_reg_write, wb_rd, wb_result,
    input  stall_d, lu_issue, lu_done_ready, rf_we, rf_wa, rf_wd, pending_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_reg_write, id_long, lu_done_valid, lu_done_data,
           wb_reg_write, wb_rd, wb_result,
    output stall_d, lu_issue, lu_done_ready, rf_we, rf_wa, rf_wd, pending_cnt
  );
endinterface

// File: rtl/rf_scoreboard_rd_tag_fifo.sv
// In-order destination-tag FIFO for long ops; pointers carry one extra wrap
// bit so full and empty are told apart without a separate counter.
module rd_tag_fifo
  import rf_sb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  regidx_t din,
  output logic    full,
  output logic    empty,
  output regidx_t head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  regidx_t     mem [DEPTH];
  logic [AW:0] wptr, rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + PTR_ONE;
      if (pop  && !empty) rptr <= rptr + PTR_ONE;
    end
  end

  // Storage needs no reset: head is only consumed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: stalls decode on hazards against in-flight long
// ops and arbitrates the single regfile write port (pipeline first).
module rf_scoreboard
  import rf_sb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  rf_scoreboard_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic            valid;
    regidx_t         rd;
    logic [XLEN-1:0] data;
  } hold_t;

  logic [NUM_REGS-1:0] busy;
  logic [CNT_W-1:0]    pend_q;
  hold_t               hold_q;

  logic    raw1, raw2, waw, full, stall, issue;
  logic    wb_hit, hold_drain, lu_ready, accept;
  logic    fifo_full, fifo_empty;
  regidx_t fifo_head;

  // Hazards are judged against registered state only, so a result draining
  // this cycle still stalls its consumer for one more cycle.
  assign raw1  = bus.id_use_rs1   && (bus.id_rs1 != '0) && busy[bus.id_rs1];
  assign raw2  = bus.id_use_rs2   && (bus.id_rs2 != '0) && busy[bus.id_rs2];
  assign waw   = bus.id_reg_write && (bus.id_rd  != '0) && busy[bus.id_rd];
  assign full  = bus.id_long && (pend_q == CNT_FULL);
  assign stall = bus.id_valid && (raw1 || raw2 || waw || full);
  assign issue = bus.id_valid && bus.id_long && !stall;

  assign wb_hit     = bus.wb_reg_write && (bus.wb_rd != '0);
  assign hold_drain = hold_q.valid && !wb_hit;
  assign lu_ready   = !fifo_empty && (!hold_q.valid || hold_drain);
  assign accept     = bus.lu_done_valid && lu_ready;

  rd_tag_fifo #(.DEPTH(DEPTH)) u_tags (
    .clk   (clk),
    .reset (reset),
    .push  (issue && !fifo_full),
    .pop   (accept),
    .din   (bus.id_rd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // An issue never targets the draining rd (WAW stalls it), so set/clear
  // cannot collide on the same bit; x0 is never set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      if (hold_drain) busy[hold_q.rd] <= 1'b0;
      if (issue && (bus.id_rd != '0)) busy[bus.id_rd] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
    end else begin
      case ({issue, hold_drain})
        2'b10:   pend_q <= pend_q + CNT_ONE;
        2'b01:   pend_q <= pend_q - CNT_ONE;
        default: pend_q <= pend_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
    end else if (accept) begin
      hold_q <= '{valid: 1'b1, rd: fifo_head, data: bus.lu_done_data};
    end else if (hold_drain) begin
      hold_q.valid <= 1'b0;
    end
  end

  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_wa = '0;
    bus.rf_wd = '0;
    if (wb_hit) begin
      bus.rf_we = 1'b1;
      bus.rf_wa = bus.wb_rd;
      bus.rf_wd = bus.wb_result;
    end else if (hold_q.valid) begin
      // rd=0 long ops still occupy a slot; only the write itself is dropped.
      bus.rf_we = (hold_q.rd != '0);
      bus.rf_wa = hold_q.rd;
      bus.rf_wd = hold_q.data;
    end
  end

  assign bus.stall_d       = stall;
  assign bus.lu_issue      = issue;
  assign bus.lu_done_ready = lu_ready;
  assign bus.pending_cnt   = pend_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: directed decode/long-unit/writeback sequences; a
// negedge monitor pops expected regfile writes from a queue and compares.
module tb_rf_scoreboard;
  import rf_sb_pkg::*;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rf_scoreboard_if #(.XLEN(XLEN), .DEPTH(DEPTH)) sb ();
  rf_scoreboard #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb.slave)
  );

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  wr_t expq[$];
  wr_t mon_e;
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expw(input logic [4:0] wa, input logic [31:0] wd);
    wr_t w;
    w.wa = wa;
    w.wd = wd;
    expq.push_back(w);
  endtask

  // Every regfile write the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (sb.rf_we === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL rf_write: got wa=%0d wd=0x%0h expected no write at %0t",
                 sb.rf_wa, sb.rf_wd, $time);
      end else begin
        mon_e = expq.pop_front();
        if (sb.rf_wa !== mon_e.wa || sb.rf_wd !== mon_e.wd) begin
          failures++;
          $display("FAIL rf_write: got wa=%0d wd=0x%0h expected wa=%0d wd=0x%0h at %0t",
                   sb.rf_wa, sb.rf_wd, mon_e.wa, mon_e.wd, $time);
        end
      end
    end else if (sb.rf_we !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL rf_we: got %b expected 0 or 1 at %0t", sb.rf_we, $time);
    end
  end

  task automatic idle();
    sb.id_valid      = 1'b0;
    sb.id_rs1        = 5'd0;
    sb.id_rs2        = 5'd0;
    sb.id_rd         = 5'd0;
    sb.id_use_rs1    = 1'b0;
    sb.id_use_rs2    = 1'b0;
    sb.id_reg_write  = 1'b0;
    sb.id_long       = 1'b0;
    sb.lu_done_valid = 1'b0;
    sb.lu_done_data  = 32'h0;
    sb.wb_reg_write  = 1'b0;
    sb.wb_rd         = 5'd0;
    sb.wb_result     = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    idle();
    sb.id_valid     = 1'b1;
    sb.id_long      = 1'b1;
    sb.id_reg_write = 1'b1;
    sb.id_rd        = rd;
    @(negedge clk);
    chk("lu_issue", 32'(sb.lu_issue), 32'd1);
    tick();
    idle();
  endtask

  // Back-to-back results; each drains the cycle after its acceptance.
  task automatic stream(input logic [4:0] rds[4], input logic [31:0] ds[4], input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && rds[i-1] != 5'd0) expw(rds[i-1], ds[i-1]);
      sb.lu_done_valid = 1'b1;
      sb.lu_done_data  = ds[i];
      @(negedge clk);
      chk("stream_ready", 32'(sb.lu_done_ready), 32'd1);
      tick();
    end
    sb.lu_done_valid = 1'b0;
    if (rds[n-1] != 5'd0) expw(rds[n-1], ds[n-1]);
    tick();
  endtask

  initial begin
    logic [4:0]  r4[4];
    logic [31:0] d4[4];
    idle();
    #2;
    chk("rst_stall",   32'(sb.stall_d),       32'd0);
    chk("rst_issue",   32'(sb.lu_issue),      32'd0);
    chk("rst_ready",   32'(sb.lu_done_ready), 32'd0);
    chk("rst_rf_we",   32'(sb.rf_we),         32'd0);
    chk("rst_pending", 32'(sb.pending_cnt),   32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // RAW against a long op on x5
    issue_long(5'd5);
    sb.id_valid = 1'b1; sb.id_use_rs1 = 1'b1; sb.id_rs1 = 5'd5;
    sb.lu_done_valid = 1'b1; sb.lu_done_data = 32'h55;
    @(negedge clk);
    chk("raw_stall_wait",  32'(sb.stall_d),       32'd1);
    chk("raw_pending",     32'(sb.pending_cnt),   32'd1);
    chk("raw_ready",       32'(sb.lu_done_ready), 32'd1);
    tick();
    sb.lu_done_valid = 1'b0;
    expw(5'd5, 32'h55);
    @(negedge clk);
    chk("raw_stall_write", 32'(sb.stall_d), 32'd1);
    tick();
    @(negedge clk);
    chk("raw_stall_clear", 32'(sb.stall_d),     32'd0);
    chk("raw_pending_0",   32'(sb.pending_cnt), 32'd0);
    tick();
    idle();

    // Write-port conflict: pipeline x3 wins for two cycles, hold waits
    issue_long(5'd7);
    issue_long(5'd13);
    sb.lu_done_valid = 1'b1; sb.lu_done_data = 32'hDEADBEEF;
    sb.wb_reg_write = 1'b1; sb.wb_rd = 5'd3; sb.wb_result = 32'h3333;
    expw(5'd3, 32'h3333);
    @(negedge clk);
    chk("pc_ready_c1",   32'(sb.lu_done_ready), 32'd1);
    chk("pc_pending_c1", 32'(sb.pending_cnt),   32'd2);
    tick();
    sb.lu_done_data = 32'hCAFE; sb.wb_result = 32'h3334;
    expw(5'd3, 32'h3334);
    @(negedge clk);
    chk("pc_ready_c2", 32'(sb.lu_done_ready), 32'd0);
    tick();
    sb.wb_reg_write = 1'b0;
    expw(5'd7, 32'hDEADBEEF);
    @(negedge clk);
    chk("pc_ready_c3",   32'(sb.lu_done_ready), 32'd1);
    chk("pc_pending_c3", 32'(sb.pending_cnt),   32'd2);
    tick();
    sb.lu_done_valid = 1'b0;
    expw(5'd13, 32'hCAFE);
    @(negedge clk);
    chk("pc_pending_c4", 32'(sb.pending_cnt),   32'd1);
    chk("pc_ready_c4",   32'(sb.lu_done_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("pc_pending_0", 32'(sb.pending_cnt), 32'd0);
    tick();
    idle();

    // Full: four outstanding, fifth waits for a drain edge
    for (int r = 1; r <= 4; r++) issue_long(5'(r));
    sb.id_valid = 1'b1; sb.id_long = 1'b1; sb.id_reg_write = 1'b1; sb.id_rd = 5'd15;
    sb.lu_done_valid = 1'b1; sb.lu_done_data = 32'hA1;
    @(negedge clk);
    chk("full_pending4", 32'(sb.pending_cnt),   32'd4);
    chk("full_stall",    32'(sb.stall_d),       32'd1);
    chk("full_noissue",  32'(sb.lu_issue),      32'd0);
    chk("full_ready",    32'(sb.lu_done_ready), 32'd1);
    tick();
    sb.lu_done_valid = 1'b0;
    expw(5'd1, 32'hA1);
    @(negedge clk);
    chk("full_drain_stall",   32'(sb.stall_d),  32'd1);
    chk("full_drain_noissue", 32'(sb.lu_issue), 32'd0);
    tick();
    @(negedge clk);
    chk("full_after_pend",  32'(sb.pending_cnt), 32'd3);
    chk("full_after_stall", 32'(sb.stall_d),     32'd0);
    chk("full_after_issue", 32'(sb.lu_issue),    32'd1);
    tick();
    idle();
    @(negedge clk);
    chk("full_pending_again", 32'(sb.pending_cnt), 32'd4);
    tick();
    r4 = '{5'd2, 5'd3, 5'd4, 5'd15};
    d4 = '{32'hA2, 32'hA3, 32'hA4, 32'hAF};
    stream(r4, d4, 4);
    @(negedge clk);
    chk("full_pending_0", 32'(sb.pending_cnt), 32'd0);
    tick();

    // In-order tags with per-register busy release
    issue_long(5'd8);
    issue_long(5'd9);
    issue_long(5'd10);
    sb.id_valid = 1'b1; sb.id_use_rs1 = 1'b1; sb.id_rs1 = 5'd8;
    sb.lu_done_valid = 1'b1; sb.lu_done_data = 32'h11;
    @(negedge clk);
    chk("ord_stall_x8", 32'(sb.stall_d), 32'd1);
    tick();
    sb.lu_done_data = 32'h22; sb.id_rs1 = 5'd9;
    expw(5'd8, 32'h11);
    @(negedge clk);
    chk("ord_stall_x9", 32'(sb.stall_d), 32'd1);
    tick();
    sb.lu_done_data = 32'h33; sb.id_rs1 = 5'd8;
    expw(5'd9, 32'h22);
    @(negedge clk);
    chk("ord_x8_free", 32'(sb.stall_d), 32'd0);
    tick();
    sb.lu_done_valid = 1'b0; sb.id_rs1 = 5'd10;
    expw(5'd10, 32'h33);
    @(negedge clk);
    chk("ord_stall_x10", 32'(sb.stall_d), 32'd1);
    tick();
    @(negedge clk);
    chk("ord_x10_free",  32'(sb.stall_d),     32'd0);
    chk("ord_pending_0", 32'(sb.pending_cnt), 32'd0);
    tick();
    idle();

    // x0 long op: no busy, no write; then WAW on busy x6
    issue_long(5'd0);
    sb.id_valid = 1'b1; sb.id_use_rs1 = 1'b1; sb.id_use_rs2 = 1'b1;
    sb.id_reg_write = 1'b1;
    sb.lu_done_valid = 1'b1; sb.lu_done_data = 32'h99;
    @(negedge clk);
    chk("x0_no_stall", 32'(sb.stall_d),     32'd0);
    chk("x0_pending",  32'(sb.pending_cnt), 32'd1);
    tick();
    sb.lu_done_valid = 1'b0;
    @(negedge clk);
    chk("x0_no_write", 32'(sb.rf_we),       32'd0);
    chk("x0_ready",    32'(sb.lu_done_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("x0_pending_0", 32'(sb.pending_cnt), 32'd0);
    tick();
    issue_long(5'd6);
    sb.id_valid = 1'b1; sb.id_reg_write = 1'b1; sb.id_rd = 5'd6;
    sb.lu_done_valid = 1'b1; sb.lu_done_data = 32'h66;
    @(negedge clk);
    chk("waw_stall", 32'(sb.stall_d), 32'd1);
    tick();
    sb.lu_done_valid = 1'b0;
    expw(5'd6, 32'h66);
    @(negedge clk);
    chk("waw_stall_write", 32'(sb.stall_d), 32'd1);
    tick();
    @(negedge clk);
    chk("waw_clear", 32'(sb.stall_d), 32'd0);
    tick();
    idle();

    // Asynchronous reset with two ops pending and the hold blocked
    issue_long(5'd11);
    issue_long(5'd12);
    sb.lu_done_valid = 1'b1; sb.lu_done_data = 32'h77;
    sb.wb_reg_write = 1'b1; sb.wb_rd = 5'd3; sb.wb_result = 32'h44;
    expw(5'd3, 32'h44);
    @(negedge clk);
    chk("ar_ready", 32'(sb.lu_done_ready), 32'd1);
    tick();
    sb.lu_done_valid = 1'b0;
    sb.id_valid = 1'b1; sb.id_use_rs1 = 1'b1; sb.id_rs1 = 5'd11;
    #1;
    chk("ar_pre_stall",   32'(sb.stall_d),     32'd1);
    chk("ar_pre_pending", 32'(sb.pending_cnt), 32'd2);
    #1;
    reset = 1'b0;
    sb.wb_reg_write = 1'b0;
    #1;
    chk("ar_stall",   32'(sb.stall_d),       32'd0);
    chk("ar_pending", 32'(sb.pending_cnt),   32'd0);
    chk("ar_ready0",  32'(sb.lu_done_ready), 32'd0);
    chk("ar_rf_we",   32'(sb.rf_we),         32'd0);
    tick();
    reset = 1'b1;
    sb.lu_done_valid = 1'b1; sb.lu_done_data = 32'hBAD;
    @(negedge clk);
    chk("ar_empty_ready", 32'(sb.lu_done_ready), 32'd0);
    chk("ar_post_stall",  32'(sb.stall_d),       32'd0);
    tick();
    idle();
    repeat (3) tick();
    chk("ar_post_pending", 32'(sb.pending_cnt), 32'd0);

    chk("expected_writes_left", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
